// File: rtl/dp_share_arbiter.sv
// Round-robin sharing of one registered datapath stage among NUM_REQ sample producers.
// Each accepted sample is issued with a one-cycle load strobe, then returned tagged with its requester index.
module dp_share_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = 8,
  parameter int HOLD_CYCLES = 2,
  parameter int ID_W        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [DATA_W-1:0]         dp_d,
  output logic                      dp_en,
  input  logic [DATA_W-1:0]         dp_q,
  output logic                      rsp_valid,
  output logic [ID_W-1:0]           rsp_id,
  output logic [DATA_W-1:0]         rsp_data,
  input  logic                      rsp_ready
);

  localparam int CNT_W = $clog2(HOLD_CYCLES) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t             state_r;
  logic [ID_W-1:0]    ptr_r;
  logic [CNT_W-1:0]   cnt_r;

  logic               found_s;
  logic               hit_s;
  logic [ID_W-1:0]    win_s;
  logic [ID_W:0]      sum_s;
  logic [ID_W-1:0]    idx_s;
  logic [ID_W:0]      win_inc_s;
  logic [ID_W-1:0]    ptr_nxt_s;
  logic [DATA_W-1:0]  win_data_s;

  // Rotating priority scan starting at ptr; the wide sum keeps the modulo in range for any NUM_REQ.
  always_comb begin
    found_s = 1'b0;
    hit_s   = 1'b0;
    win_s   = '0;
    sum_s   = '0;
    idx_s   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum_s   = {1'b0, ptr_r} + (ID_W+1)'(k);
      idx_s   = (sum_s >= (ID_W+1)'(NUM_REQ)) ? ID_W'(sum_s - (ID_W+1)'(NUM_REQ)) : ID_W'(sum_s);
      hit_s   = ~found_s & req_valid[idx_s];
      win_s   = hit_s ? idx_s : win_s;
      found_s = found_s | hit_s;
    end
  end

  // Winner's sample and the pointer position just past the winner.
  always_comb begin
    win_data_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      win_data_s = (win_s == ID_W'(i)) ? req_data[i*DATA_W +: DATA_W] : win_data_s;
    end
    win_inc_s = {1'b0, win_s} + (ID_W+1)'(1);
    ptr_nxt_s = (win_inc_s == (ID_W+1)'(NUM_REQ)) ? '0 : win_inc_s[ID_W-1:0];
  end

  // Grant is purely combinational so a requester dropping valid never leaves a stale grant.
  always_comb begin
    req_ready = '0;
    if (rstn && (state_r == IDLE) && found_s) begin
      req_ready[win_s] = 1'b1;
    end else begin
      req_ready = '0;
    end
  end

  // Issue / occupancy / response sequencing with registered datapath and response outputs.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_r   <= IDLE;
      ptr_r     <= '0;
      cnt_r     <= '0;
      dp_d      <= '0;
      dp_en     <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          dp_en <= 1'b0;
          if (found_s) begin
            dp_d    <= win_data_s;
            dp_en   <= 1'b1;
            rsp_id  <= win_s;
            ptr_r   <= ptr_nxt_s;
            cnt_r   <= CNT_W'(HOLD_CYCLES - 1);
            state_r <= EXEC;
          end
        end
        EXEC: begin
          dp_en <= 1'b0;
          if (cnt_r == '0) begin
            rsp_data  <= dp_q;
            rsp_valid <= 1'b1;
            state_r   <= RESP;
          end else begin
            cnt_r <= cnt_r - CNT_W'(1);
          end
        end
        RESP: begin
          dp_en <= 1'b0;
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state_r   <= IDLE;
          end
        end
        default: begin
          dp_en     <= 1'b0;
          rsp_valid <= 1'b0;
          state_r   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dp_share_arbiter.sv
// Directed self-checking bench for dp_share_arbiter with a one-register datapath model.
module tb_dp_share_arbiter;

  logic        clk = 1'b0;
  logic        rstn;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic [7:0]  dp_d;
  logic        dp_en;
  logic [7:0]  dp_q;
  logic        rsp_valid;
  logic [1:0]  rsp_id;
  logic [7:0]  rsp_data;
  logic        rsp_ready;

  int n_checks = 0;
  int n_errors = 0;

  dp_share_arbiter #(.NUM_REQ(4), .DATA_W(8), .HOLD_CYCLES(2)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .dp_d      (dp_d),
    .dp_en     (dp_en),
    .dp_q      (dp_q),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .rsp_ready (rsp_ready)
  );

  always #5 clk = ~clk;

  // Shared datapath: a single register loaded on the strobe.
  always_ff @(posedge clk) begin
    if (dp_en) dp_q <= dp_d;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called at the start of an IDLE cycle with requests already driven; rsp_ready must be 1.
  task automatic expect_txn(input int id, input logic [7:0] d, input logic [3:0] nv);
    #1;
    check_val("grant", {28'd0, req_ready}, 32'd1 << id);
    tick();
    req_valid = nv;
    #1;
    check_val("issue_en", {31'd0, dp_en}, 32'd1);
    check_val("issue_d", {24'd0, dp_d}, {24'd0, d});
    check_val("exec_ready", {28'd0, req_ready}, 32'd0);
    tick();
    check_val("en_pulse", {31'd0, dp_en}, 32'd0);
    check_val("rsp_early", {31'd0, rsp_valid}, 32'd0);
    tick();
    check_val("rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check_val("rsp_id", {30'd0, rsp_id}, id);
    check_val("rsp_data", {24'd0, rsp_data}, {24'd0, d});
    tick();
  endtask

  initial begin
    rstn      = 1'b0;
    req_valid = 4'hF;
    req_data  = {8'h43, 8'h32, 8'h21, 8'h10};
    rsp_ready = 1'b1;

    // Reset held for two cycles with every requester valid
    tick();
    tick();
    check_val("rst_ready", {28'd0, req_ready}, 32'd0);
    check_val("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check_val("rst_dp_en", {31'd0, dp_en}, 32'd0);
    check_val("rst_dp_d", {24'd0, dp_d}, 32'd0);
    check_val("rst_rsp_id", {30'd0, rsp_id}, 32'd0);
    check_val("rst_rsp_data", {24'd0, rsp_data}, 32'd0);
    rstn = 1'b1;
    #1;
    check_val("first_grant", {28'd0, req_ready}, 32'h1);
    req_valid = 4'h0;
    #1;
    check_val("idle_no_req", {28'd0, req_ready}, 32'h0);

    // Single request from requester 2, then requester 3 four cycles later
    req_data  = {8'h43, 8'hA5, 8'h21, 8'h10};
    req_valid = 4'b0100;
    expect_txn(2, 8'hA5, 4'b1000);
    expect_txn(3, 8'h43, 4'hF);

    // Round robin with everyone valid; ptr is 0 here
    req_data = {8'h43, 8'h32, 8'h21, 8'h10};
    expect_txn(0, 8'h10, 4'hF);
    expect_txn(1, 8'h21, 4'hF);
    expect_txn(2, 8'h32, 4'hF);
    expect_txn(3, 8'h43, 4'hF);
    expect_txn(0, 8'h10, 4'hF);
    expect_txn(1, 8'h21, 4'b0100);

    // Back-pressure: requester 2 served, response held for five cycles
    rsp_ready = 1'b0;
    #1;
    check_val("bp_grant", {28'd0, req_ready}, 32'h4);
    tick();
    req_valid = 4'hF;
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      check_val("bp_valid", {31'd0, rsp_valid}, 32'd1);
      check_val("bp_id", {30'd0, rsp_id}, 32'd2);
      check_val("bp_data", {24'd0, rsp_data}, 32'h32);
      check_val("bp_ready", {28'd0, req_ready}, 32'd0);
      check_val("bp_en", {31'd0, dp_en}, 32'd0);
      tick();
    end
    check_val("bp_still_valid", {31'd0, rsp_valid}, 32'd1);
    rsp_ready = 1'b1;
    tick();
    check_val("bp_released", {31'd0, rsp_valid}, 32'd0);
    check_val("bp_regrant", {28'd0, req_ready}, 32'h8);

    // Sparse requests 3 and 1 starting from ptr 3
    req_valid = 4'b1010;
    expect_txn(3, 8'h43, 4'b1010);
    expect_txn(1, 8'h21, 4'b1010);
    expect_txn(3, 8'h43, 4'b1010);
    expect_txn(1, 8'h21, 4'b0100);

    // Reset during EXEC: requester 2 accepted (ptr -> 3), then discarded
    #1;
    check_val("mid_grant", {28'd0, req_ready}, 32'h4);
    tick();
    check_val("mid_issue", {31'd0, dp_en}, 32'd1);
    rstn      = 1'b0;
    req_valid = 4'h0;
    #1;
    check_val("mid_rst_ready", {28'd0, req_ready}, 32'd0);
    tick();
    rstn = 1'b1;
    check_val("mid_dp_d", {24'd0, dp_d}, 32'd0);
    check_val("mid_dp_en", {31'd0, dp_en}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      check_val("mid_no_rsp", {31'd0, rsp_valid}, 32'd0);
      tick();
    end
    req_valid = 4'b1010;
    expect_txn(1, 8'h21, 4'h0);
    check_val("end_idle", {31'd0, rsp_valid}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dp_share_arbiter.md
# dp_share_arbiter

Round-robin controller that shares one registered DSP datapath stage (a clocked `d`→`q` element) between `NUM_REQ` requesters. It accepts one sample at a time through a valid/ready handshake and drives it into the datapath with a one-cycle enable. It waits a fixed occupancy, captures the datapath output, and returns it tagged with the requester index on a valid/ready response port. It sits between the sample producers and the shared datapath instance and is the only block allowed to drive that datapath's inputs.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..16.
- `DATA_W`, 8: sample width, ≥1.
- `HOLD_CYCLES`, 2: datapath occupancy in cycles from issue to capture, ≥1.
- `ID_W`, derived, max(1, clog2(NUM_REQ)): width of `rsp_id`.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rstn`  in  1  reset, synchronous, active-low.
- `req_valid`  in  NUM_REQ  per-requester sample valid.
- `req_data`  in  NUM_REQ*DATA_W  requester i occupies bits [i*DATA_W +: DATA_W].
- `req_ready`  out  NUM_REQ  one-hot-or-zero grant; transfer when `req_valid[i] & req_ready[i]`.
- `dp_d`  out  DATA_W  datapath input sample.
- `dp_en`  out  1  one-cycle datapath load strobe.
- `dp_q`  in  DATA_W  datapath output.
- `rsp_valid`  out  1  response valid.
- `rsp_id`  out  ID_W  index of the requester that produced the response.
- `rsp_data`  out  DATA_W  captured `dp_q`.
- `rsp_ready`  in  1  response consumer ready.

## Operation
- FSM states:
  - IDLE: arbitrate among valid requesters.
  - EXEC: datapath occupied; `cnt` loads HOLD_CYCLES-1 on entry and decrements each cycle.
  - RESP: response held until consumed.
- IDLE: the winner is the first i with `req_valid[i]=1`, scanning `ptr`, `ptr+1`, … modulo NUM_REQ.
  - `req_ready[winner]=1`; all other `req_ready` bits are 0.
  - If no request is valid, `req_ready=0` and the FSM stays in IDLE.
- On accept of requester i:
  - latch `req_data[i]` into `dp_d` and i into the id register;
  - `ptr ← (i+1) mod NUM_REQ`;
  - go to EXEC.
- `ptr` changes only on an accept.
- Requesters may drop `req_valid` without a grant. Arbitration is re-evaluated every IDLE cycle with no stored grant.
- `req_ready` is 0 in EXEC and RESP and in any cycle where `rstn=0`.
- EXEC:
  - `dp_en=1` in the first EXEC cycle only.
  - `dp_d` holds the accepted sample throughout.
  - In the cycle `cnt==0`, latch `dp_q` into `rsp_data` and go to RESP.
- RESP:
  - `rsp_valid=1`; `rsp_id` and `rsp_data` are stable.
  - On `rsp_valid & rsp_ready`, go to IDLE next cycle.
  - `rsp_valid` stays high with unchanged id/data until the response is consumed.
- `dp_d` retains its last issued value outside EXEC. `dp_en=0` outside the first EXEC cycle.
- Reset (rising edge with `rstn=0`), from any state:
  - state IDLE, `ptr=0`, `cnt=0`;
  - `dp_d=0`, `dp_en=0`, `rsp_valid=0`, `rsp_id=0`, `rsp_data=0`.
  - An in-flight transaction is discarded and produces no response.
- Widths: `cnt` is clog2(HOLD_CYCLES)+1 bits. `ptr` is ID_W bits and wraps from NUM_REQ-1 to 0. Non-power-of-two NUM_REQ never produces an out-of-range index.

## Timing
- Accept on edge T (IDLE, valid & ready).
- Cycles T+1 … T+HOLD_CYCLES are EXEC; `dp_en=1` only in cycle T+1.
- `rsp_data` is captured from `dp_q` at the end of cycle T+HOLD_CYCLES. For a one-register datapath, `dp_q` reflects the sample from cycle T+2 onward, so HOLD_CYCLES=1 is illegal for that datapath; the default is 2.
- `rsp_valid` rises in cycle T+HOLD_CYCLES+1, giving an accept-to-response latency of HOLD_CYCLES+1 cycles.
- With `rsp_ready` tied high, the next accept is possible in cycle T+HOLD_CYCLES+2. Maximum throughput is one sample per HOLD_CYCLES+2 cycles.
- `req_ready` is combinational from state, `ptr` and `req_valid`. All other outputs are registered.

## Test plan
- Reset:
  - Hold `rstn=0` for 2 cycles with all `req_valid=1` → `req_ready=0`, `rsp_valid=0`, `dp_en=0`, `dp_d=0`.
  - After release, the first grant goes to requester 0.
- Single request: requester 2 sends 0xA5, `rsp_ready=1`, default params →
  - `dp_en` pulses 1 cycle after accept with `dp_d=0xA5`;
  - `rsp_valid` asserts 3 cycles after accept with `rsp_id=2`, `rsp_data=0xA5`;
  - the next accept occurs 4 cycles after the first.
- Round-robin: all 4 requesters continuously valid with data 0x10, 0x21, 0x32, 0x43 → grant order 0,1,2,3,0,1,…; responses carry the matching id/data, with no requester granted twice before the others.
- Back-pressure: hold `rsp_ready=0` for 5 cycles in RESP → `rsp_valid`, `rsp_id` and `rsp_data` are stable, `req_ready=0` and `dp_en=0` throughout; one cycle after `rsp_ready=1`, the FSM is in IDLE and grants.
- Pointer wrap with sparse requests: only requesters 3 and 1 valid, `ptr` at 3 → grant 3, then 1, then 3; `ptr` wraps to 0 correctly.
- Reset mid-operation: assert `rstn=0` for 1 cycle in EXEC → no response is ever produced for that sample; the FSM returns to IDLE with `ptr=0`; a subsequent request completes normally.
